// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter.
// MEM_ARB_STATS_EN enables the optional per-port grant counters in the top level.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;

endpackage

// File: rtl/mem_ram_arbiter_if.sv
// One requester port of the data-RAM arbiter.
// Handshake: the requester raises req with we/lock/addr/wdata and holds them stable until it sees
// gnt high in a cycle; that cycle performs the access. A read returns rdata with a 1-cycle rvalid pulse
// one cycle later. Dropping req before gnt cancels the request with no access.
interface mem_ram_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
);
    logic          req;
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;

    modport master (output req, we, lock, addr, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arb_rr_pick.sv
// Round-robin choice between two requesters: on a tie the port that was not served last wins.
module mem_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic pick_valid,
    output logic pick
);
    always_comb begin
        pick_valid = req0 | req1;
        pick       = (req0 & req1) ? ~last : req1;
    end
endmodule

// File: rtl/mem_ram_arbiter.sv
// Two-port round-robin arbiter for the single-port data RAM, with bounded burst lock and
// registered read return. Define MEM_ARB_STATS_EN to add saturating per-port grant counters.
module mem_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_ram_arbiter_if.slave  p0,
    mem_ram_arbiter_if.slave  p1,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_wdata,
    input  logic [DW-1:0]     ram_rdata,
`ifdef MEM_ARB_STATS_EN
    output logic [31:0]       stat_p0_cnt,
    output logic [31:0]       stat_p1_cnt,
`endif
    output logic [1:0]        dbg_state
);

    localparam int LCW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(MAX_LOCK - 1);

    arb_state_e     state_q, state_d;
    logic           last_q, last_d;
    logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
    logic           rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [DW-1:0]  rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic gnt0, gnt1;
    logic own1, x_req, x_lock, y_req;
    logic pick_last, pick_valid, pick;

    assign own1   = (state_q == ST_OWN1);
    assign gnt0   = (state_q == ST_OWN0) & p0.req;
    assign gnt1   = own1 & p1.req;
    assign x_req  = own1 ? p1.req  : p0.req;
    assign x_lock = own1 ? p1.lock : p0.lock;
    assign y_req  = own1 ? p0.req  : p1.req;

    // While owning, treating the owner as "last" turns the picker into the hand-off rule:
    // the other port if it waits, else the owner again, else nobody.
    assign pick_last = (state_q == ST_IDLE) ? last_q : own1;

    mem_arb_rr_pick u_pick (
        .req0       (p0.req),
        .req1       (p1.req),
        .last       (pick_last),
        .pick_valid (pick_valid),
        .pick       (pick)
    );

    always_comb begin
        state_d    = ST_IDLE;
        lock_cnt_d = '0;
        last_d     = last_q;
        ram_addr   = '0;
        ram_we     = 1'b0;
        ram_wdata  = '0;

        if (gnt0) begin
            ram_addr  = p0.addr;
            ram_we    = p0.we;
            ram_wdata = p0.wdata;
            last_d    = PORT0;
        end else if (gnt1) begin
            ram_addr  = p1.addr;
            ram_we    = p1.we;
            ram_wdata = p1.wdata;
            last_d    = PORT1;
        end
        ram_we = ram_we & ~rst;

        case (state_q)
            ST_OWN0, ST_OWN1: begin
                if (x_req && x_lock && ((lock_cnt_q < LOCK_LAST) || !y_req)) begin
                    state_d    = state_q;
                    lock_cnt_d = (lock_cnt_q == LOCK_LAST) ? lock_cnt_q : lock_cnt_q + LCW'(1);
                end else if (pick_valid) begin
                    state_d = pick ? ST_OWN1 : ST_OWN0;
                end
            end
            default: begin
                if (pick_valid) state_d = pick ? ST_OWN1 : ST_OWN0;
            end
        endcase

        rvalid0_d = gnt0 & ~p0.we;
        rvalid1_d = gnt1 & ~p1.we;
        rdata0_d  = rvalid0_d ? ram_rdata : rdata0_q;
        rdata1_d  = rvalid1_d ? ram_rdata : rdata1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            last_q     <= PORT1;
            lock_cnt_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            rvalid0_q  <= rvalid0_d;
            rvalid1_q  <= rvalid1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign p0.gnt    = gnt0;
    assign p1.gnt    = gnt1;
    assign p0.rvalid = rvalid0_q;
    assign p1.rvalid = rvalid1_q;
    assign p0.rdata  = rdata0_q;
    assign p1.rdata  = rdata1_q;
    assign dbg_state = state_q;

`ifdef MEM_ARB_STATS_EN
    logic [31:0] stat0_q, stat0_d, stat1_q, stat1_d;

    always_comb begin
        stat0_d = (gnt0 && (stat0_q != '1)) ? stat0_q + 32'd1 : stat0_q;
        stat1_d = (gnt1 && (stat1_q != '1)) ? stat1_q + 32'd1 : stat1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat0_q <= '0;
            stat1_q <= '0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat_p0_cnt = stat0_q;
    assign stat_p1_cnt = stat1_q;
`endif

endmodule

// File: tb/tb_mem_ram_arbiter.sv
// Directed bench for mem_ram_arbiter with a behavioural single-port RAM behind it.
// Build with MEM_ARB_STATS_EN to also exercise the grant counters.
module tb_mem_ram_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    // clock / reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_ram_arbiter_if #(.AW(AW), .DW(DW)) p0_if ();
    mem_ram_arbiter_if #(.AW(AW), .DW(DW)) p1_if ();

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    dbg_state;
`ifdef MEM_ARB_STATS_EN
    logic [31:0]   stat_p0_cnt;
    logic [31:0]   stat_p1_cnt;
`endif

    mem_ram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .p0        (p0_if),
        .p1        (p1_if),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
`ifdef MEM_ARB_STATS_EN
        .stat_p0_cnt (stat_p0_cnt),
        .stat_p1_cnt (stat_p1_cnt),
`endif
        .dbg_state (dbg_state)
    );

    logic [DW-1:0] mem [0:255];
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;
    assign ram_rdata = mem[ram_addr];

    // scoreboard
    int n_checks = 0;
    int n_bad    = 0;
    logic [1:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int port, input logic req, input logic we, input logic lock,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (port == 0) begin
            p0_if.req = req; p0_if.we = we; p0_if.lock = lock; p0_if.addr = addr; p0_if.wdata = wdata;
        end else begin
            p1_if.req = req; p1_if.we = we; p1_if.lock = lock; p1_if.addr = addr; p1_if.wdata = wdata;
        end
    endtask

    // Returns one cycle after the grant cycle with req already dropped.
    task automatic access(input int port, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, output int waited);
        logic g;
        g = 1'b0;
        waited = 0;
        set_port(port, 1'b1, we, 1'b0, addr, wdata);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            g = (port == 0) ? p0_if.gnt : p1_if.gnt;
            if (g) break;
            waited++;
            tick();
        end
        if (!g) check("access_timeout", 32'(g), 32'd1);
        tick();
        set_port(port, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, max0, max1, run0, run1;
        logic [7:0] beats1;
        logic p0_done;
        logic [1:0] obs, expg;

        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(0, 1'b1, 1'b1, 1'b0, 8'h00, 32'h1111_1111);

        // reset with p0 requesting
        repeat (2) begin
            @(negedge clk);
            check("rst_gnt",    32'(p0_if.gnt),    32'd0);
            check("rst_we",     32'(ram_we),       32'd0);
            check("rst_rvalid", 32'(p0_if.rvalid), 32'd0);
            tick();
        end
        check("rst_rdata", p0_if.rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("first_gnt_early", 32'(p0_if.gnt), 32'd0);
        tick();
        @(negedge clk);
        check("first_gnt", 32'(p0_if.gnt), 32'd1);
        tick();
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("first_wr_no_rvalid", 32'(p0_if.rvalid), 32'd0);
        tick();

        // p0 write then read back
        access(0, 1'b1, 8'h10, 32'hDEAD_BEEF, w);
        check("wr_latency", 32'(w), 32'd1);
        @(negedge clk);
        check("wr_no_rvalid", 32'(p0_if.rvalid), 32'd0);
        tick();
        access(0, 1'b0, 8'h10, '0, w);
        check("rd_latency", 32'(w), 32'd1);
        @(negedge clk);
        check("rd_rvalid", 32'(p0_if.rvalid), 32'd1);
        check("rd_rdata",  p0_if.rdata, 32'hDEAD_BEEF);
        tick();
        @(negedge clk);
        check("rd_rvalid_pulse", 32'(p0_if.rvalid), 32'd0);
        check("rd_rdata_hold",   p0_if.rdata, 32'hDEAD_BEEF);
        tick();

        // both requesting, no lock: alternation starting with p1 (p0 served last)
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h10, '0);
        set_port(1, 1'b1, 1'b0, 1'b0, 8'h20, '0);
        exp_q = '{2'd0, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd2};
        max0 = 0; max1 = 0; run0 = 0; run1 = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs  = {p1_if.gnt, p0_if.gnt};
            expg = exp_q.pop_front();
            check($sformatf("alt_c%0d", c), 32'(obs), 32'(expg));
            run0 = obs[0] ? 0 : run0 + 1;
            run1 = obs[1] ? 0 : run1 + 1;
            if (run0 > max0) max0 = run0;
            if (run1 > max1) max1 = run1;
            tick();
        end
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("fair_p0", 32'(max0 <= 2), 32'd1);
        check("fair_p1", 32'(max1 <= 2), 32'd1);
        tick();
        tick();

        // p1 locked write burst of 8 while p0 waits
        exp_q = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
        beats1 = 8'd0;
        p0_done = 1'b0;
        for (int c = 0; c < 11; c++) begin
            if (beats1 < 8'd8)
                set_port(1, 1'b1, 1'b1, beats1 < 8'd7, 8'(8'h40 + beats1), 32'(32'hA0 + beats1));
            else
                set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
            set_port(0, (c >= 1) && !p0_done, 1'b1, 1'b0, 8'h50, 32'h55);
            @(negedge clk);
            obs  = {p1_if.gnt, p0_if.gnt};
            expg = exp_q.pop_front();
            check($sformatf("lock_c%0d", c), 32'(obs), 32'(expg));
            if (obs[1]) beats1++;
            if (obs[0]) p0_done = 1'b1;
            tick();
        end
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, 1'b0, '0, '0);
        check("burst_beat3", mem[8'h43], 32'hA3);
        check("burst_beat7", mem[8'h47], 32'hA7);
        check("burst_p0_wr", mem[8'h50], 32'h55);
        tick();
        tick();

        // reset during a p0 write grant, then during a p0 read grant
        access(0, 1'b1, 8'h30, 32'h1234_5678, w);
        tick();
        set_port(0, 1'b1, 1'b1, 1'b0, 8'h30, 32'hBADB_AD00);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_we", 32'(ram_we), 32'd0);
        tick();
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_mid_state",  32'(dbg_state), 32'd0);
        check("rst_mid_rvalid", 32'(p0_if.rvalid), 32'd0);
        check("rst_mid_mem",    mem[8'h30], 32'h1234_5678);
        tick();
        set_port(0, 1'b1, 1'b0, 1'b0, 8'h30, '0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("rst_rd_cancel", 32'(p0_if.rvalid), 32'd0);
        tick();
        access(0, 1'b0, 8'h30, '0, w);
        @(negedge clk);
        check("post_rst_rd", p0_if.rdata, 32'h1234_5678);
        tick();

`ifdef MEM_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            access(0, 1'b1, 8'(8'h60 + i), 32'(i), w);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            access(1, 1'b0, 8'(8'h60 + i), '0, w);
            tick();
        end
        @(negedge clk);
        check("stat_p0", stat_p0_cnt, 32'd5);
        check("stat_p1", stat_p1_cnt, 32'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("stat_p0_rst", stat_p0_cnt, 32'd0);
        check("stat_p1_rst", stat_p1_cnt, 32'd0);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
